// File: rtl/rocc_accum_unit.sv
// RoCC responder executing WRITE/READ/ADD and an iterative shift-add MAC on a small
// bank of accumulators; results return over a valid/ready response channel.
module rocc_accum_unit #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned NrAcc   = 4,
  parameter int unsigned MulBits = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            rocc_cmd_valid_i,
  output logic            rocc_cmd_ready_o,
  input  logic [6:0]      cmd_funct7_i,
  input  logic [XLEN-1:0] cmd_rs1_i,
  input  logic [XLEN-1:0] cmd_rs2_i,
  input  logic [4:0]      cmd_rd_i,
  input  logic            cmd_xd_i,
  output logic            rocc_resp_valid_o,
  input  logic            rocc_resp_ready_i,
  output logic [4:0]      resp_rd_o,
  output logic [XLEN-1:0] resp_data_o,
  output logic            busy_o,
  output logic            illegal_o
);

  localparam int unsigned CntW = (MulBits > 1) ? $clog2(MulBits) : 1;

  localparam logic [1:0] OpWrite = 2'd0;
  localparam logic [1:0] OpRead  = 2'd1;
  localparam logic [1:0] OpAdd   = 2'd2;
  localparam logic [1:0] OpMac   = 2'd3;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e              state_q, state_d;
  logic [XLEN-1:0]     acc_q [NrAcc];
  logic [XLEN-1:0]     acc_d [NrAcc];
  logic [1:0]          idx_q, idx_d;
  logic [4:0]          rd_q, rd_d;
  logic                xd_q, xd_d;
  logic [XLEN-1:0]     mcand_q, mcand_d;
  logic [MulBits-1:0]  mplier_q, mplier_d;
  logic [XLEN-1:0]     prod_q, prod_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [4:0]          resp_rd_q, resp_rd_d;
  logic [XLEN-1:0]     resp_data_q, resp_data_d;
  logic                illegal_q, illegal_d;

  logic [1:0]          cmd_op;
  logic [1:0]          cmd_idx;
  logic                cmd_fire;
  logic                cmd_illegal;
  logic [XLEN-1:0]     result;
  logic [XLEN-1:0]     prod_step;

  assign cmd_op      = cmd_funct7_i[1:0];
  assign cmd_idx     = cmd_funct7_i[3:2];
  assign cmd_fire    = rocc_cmd_valid_i && (state_q == StIdle);
  assign cmd_illegal = (|cmd_funct7_i[6:4]) || (32'(cmd_idx) >= NrAcc);

  assign rocc_cmd_ready_o  = (state_q == StIdle);
  assign rocc_resp_valid_o = (state_q == StResp);
  assign busy_o            = (state_q != StIdle);
  assign resp_rd_o         = resp_rd_q;
  assign resp_data_o       = resp_data_q;
  assign illegal_o         = illegal_q;

  // Partial product including the current multiplier bit.
  assign prod_step = mplier_q[0] ? (prod_q + mcand_q) : prod_q;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    idx_d       = idx_q;
    rd_d        = rd_q;
    xd_d        = xd_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    resp_rd_d   = resp_rd_q;
    resp_data_d = resp_data_q;
    illegal_d   = illegal_q;
    result      = '0;

    unique case (state_q)
      StIdle: begin
        if (cmd_fire) begin
          idx_d = cmd_idx;
          rd_d  = cmd_rd_i;
          xd_d  = cmd_xd_i;
          if (cmd_illegal) begin
            illegal_d = 1'b1;
            result    = '1;
          end else begin
            unique case (cmd_op)
              OpWrite: begin
                acc_d[cmd_idx] = cmd_rs1_i;
                result         = cmd_rs1_i;
              end
              OpRead: result = acc_q[cmd_idx];
              OpAdd: begin
                result         = acc_q[cmd_idx] + cmd_rs1_i;
                acc_d[cmd_idx] = result;
              end
              OpMac: begin
                mcand_d  = XLEN'(cmd_rs1_i[MulBits-1:0]);
                mplier_d = cmd_rs2_i[MulBits-1:0];
                prod_d   = '0;
                cnt_d    = '0;
                state_d  = StExec;
              end
              default: ;
            endcase
          end
          if (cmd_xd_i && (cmd_illegal || cmd_op != OpMac)) begin
            state_d     = StResp;
            resp_rd_d   = cmd_rd_i;
            resp_data_d = result;
          end
        end
      end
      StExec: begin
        prod_d   = prod_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CntW'(MulBits - 1)) begin
          result       = acc_q[idx_q] + prod_step;
          acc_d[idx_q] = result;
          if (xd_q) begin
            state_d     = StResp;
            resp_rd_d   = rd_q;
            resp_data_d = result;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StResp: begin
        if (rocc_resp_ready_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      for (int i = 0; i < NrAcc; i++) acc_q[i] <= '0;
      idx_q       <= '0;
      rd_q        <= '0;
      xd_q        <= 1'b0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      resp_rd_q   <= '0;
      resp_data_q <= '0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      xd_q        <= xd_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      resp_rd_q   <= resp_rd_d;
      resp_data_q <= resp_data_d;
      illegal_q   <= illegal_d;
    end
  end

endmodule
